// File: rtl/mux_scan_nx1.sv
// N-channel, W-bit registered multiplexer with manual select and automatic dwell-timed scan.
// Optional per-channel enable mask for scan/manual selection when MUX_SCAN_MASK_EN is defined.
module mux_scan_nx1 #(
  parameter int N_CH    = 4,
  parameter int W       = 8,
  parameter int SEL_W   = 2,
  parameter int DWELL_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                mode,
  input  logic [SEL_W-1:0]    sel,
  input  logic [DWELL_W-1:0]  dwell,
  input  logic [N_CH*W-1:0]   in_data,
`ifdef MUX_SCAN_MASK_EN
  input  logic [N_CH-1:0]     ch_mask,
`endif
  output logic [W-1:0]        out_data,
  output logic [SEL_W-1:0]    out_ch,
  output logic                out_valid,
  output logic                scan_wrap
);

  typedef enum logic [1:0] {IDLE, MANUAL, SCAN} state_t;

  state_t              r_state, w_state_nxt;
  logic [SEL_W-1:0]    r_cur_ch, w_cur_nxt;
  logic [DWELL_W-1:0]  r_cnt, w_cnt_nxt;
  logic [W-1:0]        r_out_data, w_data_nxt;
  logic [SEL_W-1:0]    r_out_ch, w_ch_nxt;
  logic                r_out_valid, w_valid_nxt;
  logic                r_scan_wrap, w_wrap_nxt;

  logic [N_CH-1:0]     w_mask;
  logic [SEL_W-1:0]    w_first, w_above;
  logic                w_any, w_has_above;
  logic                w_sel_ok;
  logic [W-1:0]        w_sel_data, w_scan_data;

`ifdef MUX_SCAN_MASK_EN
  assign w_mask = ch_mask;
`else
  assign w_mask = '1;
`endif

  // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_state_nxt = r_state;
    w_cur_nxt   = r_cur_ch;
    w_cnt_nxt   = r_cnt;
    w_data_nxt  = r_out_data;
    w_ch_nxt    = r_out_ch;
    w_valid_nxt = 1'b0;
    w_wrap_nxt  = 1'b0;
    w_sel_ok    = 1'b0;
    w_sel_data  = '0;
    w_scan_data = '0;
    w_first     = '0;
    w_any       = 1'b0;
    w_above     = '0;
    w_has_above = 1'b0;

    // Descending loops leave the lowest qualifying index in place.
    for (int k = N_CH-1; k >= 0; k--) begin
      if (w_mask[k]) begin
        w_first = SEL_W'(k);
        w_any   = 1'b1;
      end
      if (w_mask[k] && (k > int'(r_cur_ch))) begin
        w_above     = SEL_W'(k);
        w_has_above = 1'b1;
      end
    end

    if (!en)        w_state_nxt = IDLE;
    else if (!mode) w_state_nxt = MANUAL;
    else            w_state_nxt = SCAN;

    case (w_state_nxt)
      MANUAL: begin
        for (int k = 0; k < N_CH; k++) begin
          if ((int'(sel) == k) && w_mask[k]) begin
            w_sel_ok   = 1'b1;
            w_sel_data = in_data[k*W +: W];
          end
        end
        w_ch_nxt    = sel;
        w_data_nxt  = w_sel_data;
        w_valid_nxt = w_sel_ok;
      end
      SCAN: begin
        if (r_state != SCAN) begin
          w_cur_nxt = w_first;
          w_cnt_nxt = dwell;
        end else if (w_any) begin
          if (r_cnt == '0) begin
            w_cnt_nxt = dwell;
            if (w_has_above) begin
              w_cur_nxt = w_above;
            end else begin
              w_cur_nxt  = w_first;
              w_wrap_nxt = 1'b1;
            end
          end else begin
            w_cnt_nxt = r_cnt - DWELL_W'(1);
          end
        end
        for (int k = 0; k < N_CH; k++) begin
          if (int'(w_cur_nxt) == k) w_scan_data = in_data[k*W +: W];
        end
        // With every channel masked the previous output is held and flagged invalid.
        if (w_any) begin
          w_ch_nxt    = w_cur_nxt;
          w_data_nxt  = w_scan_data;
          w_valid_nxt = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cur_ch    <= '0;
      r_cnt       <= '0;
      r_out_data  <= '0;
      r_out_ch    <= '0;
      r_out_valid <= 1'b0;
      r_scan_wrap <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cur_ch    <= w_cur_nxt;
      r_cnt       <= w_cnt_nxt;
      r_out_data  <= w_data_nxt;
      r_out_ch    <= w_ch_nxt;
      r_out_valid <= w_valid_nxt;
      r_scan_wrap <= w_wrap_nxt;
    end
  end

  assign out_data  = r_out_data;
  assign out_ch    = r_out_ch;
  assign out_valid = r_out_valid;
  assign scan_wrap = r_scan_wrap;

endmodule

// File: tb/tb_mux_scan_nx1.sv
// Self-checking bench for mux_scan_nx1: a 4-channel and a 3-channel instance share stimulus
// and are compared every cycle against an integer-level model, plus directed literal checks.
module tb_mux_scan_nx1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        en = 1'b0;
  logic        mode = 1'b0;
  logic [1:0]  sel = '0;
  logic [3:0]  dwell = '0;
  logic [31:0] din = '0;
  logic [3:0]  mask = 4'hF;

  logic [7:0]  o4_data, o3_data;
  logic [1:0]  o4_ch, o3_ch;
  logic        o4_valid, o3_valid, o4_wrap, o3_wrap;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mux_scan_nx1 #(.N_CH(4), .W(8), .SEL_W(2), .DWELL_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel), .dwell(dwell),
    .in_data(din),
`ifdef MUX_SCAN_MASK_EN
    .ch_mask(mask),
`endif
    .out_data(o4_data), .out_ch(o4_ch), .out_valid(o4_valid), .scan_wrap(o4_wrap)
  );

  mux_scan_nx1 #(.N_CH(3), .W(8), .SEL_W(2), .DWELL_W(4)) dut3 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel), .dwell(dwell),
    .in_data(din[23:0]),
`ifdef MUX_SCAN_MASK_EN
    .ch_mask(mask[2:0]),
`endif
    .out_data(o3_data), .out_ch(o3_ch), .out_valid(o3_valid), .scan_wrap(o3_wrap)
  );

  typedef struct {
    bit   scan;
    int   cur;
    int   rem;
    int   data;
    int   ch;
    bit   valid;
    bit   wrap;
  } model_t;

  model_t m4, m3;

  function automatic model_t model_reset();
    model_t m;
    m.scan = 0; m.cur = 0; m.rem = 0; m.data = 0; m.ch = 0; m.valid = 0; m.wrap = 0;
    return m;
  endfunction

  // One clock edge of the mux as described behaviourally: n channels, byte-wide data.
  function automatic model_t model_step(model_t m, int n, logic [31:0] d, bit e, bit md,
                                        int s, int dw, logic [3:0] mk_in);
    logic [3:0] mk;
    int first;
    int nxt;
    bit any;
    mk = mk_in & 4'((1 << n) - 1);
    first = -1;
    for (int k = 0; k < n; k++) if (mk[k] && first < 0) first = k;
    any = (first >= 0);
    m.wrap = 0;
    if (!e) begin
      m.scan = 0;
      m.valid = 0;
    end else if (!md) begin
      m.scan = 0;
      m.ch = s;
      if (s < n && mk[s]) begin
        m.valid = 1;
        m.data = int'(d[s*8 +: 8]);
      end else begin
        m.valid = 0;
        m.data = 0;
      end
    end else begin
      if (!m.scan) begin
        m.scan = 1;
        m.cur = any ? first : 0;
        m.rem = dw;
      end else if (any) begin
        if (m.rem > 0) begin
          m.rem = m.rem - 1;
        end else begin
          nxt = -1;
          for (int k = n-1; k > m.cur; k--) if (mk[k]) nxt = k;
          if (nxt < 0) begin
            nxt = first;
            m.wrap = 1;
          end
          m.cur = nxt;
          m.rem = dw;
        end
      end
      if (any) begin
        m.valid = 1;
        m.ch = m.cur;
        m.data = int'(d[m.cur*8 +: 8]);
      end else begin
        m.valid = 0;
      end
    end
    return m;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m4 = model_reset();
      m3 = model_reset();
    end else begin
      m4 = model_step(m4, 4, din, en, mode, int'(sel), int'(dwell), mask);
      m3 = model_step(m3, 3, din, en, mode, int'(sel), int'(dwell), mask);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("d4_data",  32'(o4_data),  32'(m4.data));
    check("d4_ch",    32'(o4_ch),    32'(m4.ch));
    check("d4_valid", 32'(o4_valid), 32'(m4.valid));
    check("d4_wrap",  32'(o4_wrap),  32'(m4.wrap));
    check("d3_data",  32'(o3_data),  32'(m3.data));
    check("d3_ch",    32'(o3_ch),    32'(m3.ch));
    check("d3_valid", 32'(o3_valid), 32'(m3.valid));
    check("d3_wrap",  32'(o3_wrap),  32'(m3.wrap));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] exp_man [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
  int exp_ch0 [6] = '{0, 1, 2, 3, 0, 1};
  int exp_wr0 [6] = '{0, 0, 0, 0, 1, 0};
  int exp_chd [4] = '{1, 1, 2, 3};

  initial begin
    #1 rst_n = 1'b0;
    #2;
    check("rst_data",  32'(o4_data),  32'h0);
    check("rst_valid", 32'(o4_valid), 32'h0);
    tick();
    rst_n = 1'b1;
    tick(); tick();
    check("idle_valid", 32'(o4_valid), 32'h0);

    // Manual select
    din = 32'hD4C3B2A1; en = 1'b1; mode = 1'b0;
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      tick();
      check("man_data",  32'(o4_data),  32'(exp_man[s]));
      check("man_ch",    32'(o4_ch),    32'(s));
      check("man_valid", 32'(o4_valid), 32'h1);
    end
    check("man3_oor_valid", 32'(o3_valid), 32'h0);
    check("man3_oor_data",  32'(o3_data),  32'h0);

    // Scan, dwell 0
    mode = 1'b1; dwell = 4'd0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("scan0_ch",   32'(o4_ch),   32'(exp_ch0[i]));
      check("scan0_wrap", 32'(o4_wrap), 32'(exp_wr0[i]));
    end

    // Scan, dwell 2: 12-cycle period
    mode = 1'b0; tick();
    mode = 1'b1; dwell = 4'd2;
    for (int i = 0; i < 13; i++) begin
      tick();
      check("scan2_ch",   32'(o4_ch),   32'((i / 3) % 4));
      check("scan2_wrap", 32'(o4_wrap), 32'(i == 12));
    end

    // Dwell change during channel 1 applies from channel 2
    mode = 1'b0; tick();
    mode = 1'b1; dwell = 4'd2;
    for (int i = 0; i < 4; i++) tick();
    check("dchg_first_ch1", 32'(o4_ch), 32'h1);
    dwell = 4'd0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("dchg_ch", 32'(o4_ch), 32'(exp_chd[i]));
    end

    // Mode / enable switching
    mode = 1'b0; tick();
    mode = 1'b1; tick(); tick(); tick();
    check("sw_at_ch2", 32'(o4_ch), 32'h2);
    mode = 1'b0; sel = 2'd1; tick();
    check("sw_man_ch",   32'(o4_ch),   32'h1);
    check("sw_man_data", 32'(o4_data), 32'hB2);
    mode = 1'b1; tick();
    check("sw_rescan_ch",   32'(o4_ch),   32'h0);
    check("sw_rescan_wrap", 32'(o4_wrap), 32'h0);
    en = 1'b0; tick();
    check("sw_en_off_valid", 32'(o4_valid), 32'h0);
    check("sw_en_off_ch",    32'(o4_ch),    32'h0);

    // Asynchronous reset mid-scan at channel 2
    en = 1'b1; mode = 1'b1; dwell = 4'd0;
    tick(); tick(); tick();
    check("rs_pre_ch", 32'(o4_ch), 32'h2);
    #2 rst_n = 1'b0;
    #1;
    check("rs_data",  32'(o4_data),  32'h0);
    check("rs_ch",    32'(o4_ch),    32'h0);
    check("rs_valid", 32'(o4_valid), 32'h0);
    check("rs_wrap",  32'(o4_wrap),  32'h0);
    en = 1'b0;
    #2 rst_n = 1'b1;
    tick(); tick();
    check("rs_idle_valid", 32'(o4_valid), 32'h0);

`ifdef MUX_SCAN_MASK_EN
    mask = 4'b1010; dwell = 4'd0; en = 1'b1; mode = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("mask_ch",   32'(o4_ch),   32'((i % 2 == 0) ? 1 : 3));
      check("mask_wrap", 32'(o4_wrap), 32'(i == 2));
    end
    mask = 4'b0000; tick();
    check("mask_none_valid", 32'(o4_valid), 32'h0);
    en = 1'b0; mask = 4'hF; tick();
`endif

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      en = ($urandom_range(19) != 0);
      if ($urandom_range(14) == 0) mode = ~mode;
      sel = 2'($urandom_range(3));
      if ($urandom_range(3) == 0) dwell = 4'($urandom_range(3));
      din = $urandom;
`ifdef MUX_SCAN_MASK_EN
      if (!en) mask = 4'($urandom_range(15, 1));
`endif
      tick();
    end

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
